// File: rtl/sca_cmd_pkg.sv
// Shared constants, FSM state encoding and frame field layout for the SCA command receiver.
package sca_cmd_pkg;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned FRAME_LEN = 12;
    localparam int unsigned IDX_W     = 4;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;
    localparam logic [7:0] ERR_MAX   = 8'hFF;

    // Byte position of each field within a frame; position 0 is the sync byte.
    localparam logic [IDX_W-1:0] IDX_SEL  = 4'd1;
    localparam logic [IDX_W-1:0] IDX_ADDR = 4'd2;
    localparam logic [IDX_W-1:0] IDX_TID  = 4'd3;
    localparam logic [IDX_W-1:0] IDX_CHAN = 4'd4;
    localparam logic [IDX_W-1:0] IDX_CMD  = 4'd5;
    localparam logic [IDX_W-1:0] IDX_LEN  = 4'd6;
    localparam logic [IDX_W-1:0] IDX_D3   = 4'd7;
    localparam logic [IDX_W-1:0] IDX_D2   = 4'd8;
    localparam logic [IDX_W-1:0] IDX_D1   = 4'd9;
    localparam logic [IDX_W-1:0] IDX_D0   = 4'd10;
    localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_WAIT_READY,
        ST_ISSUE
    } state_e;

    // Assembled payload of one command frame.
    typedef struct packed {
        logic [BYTE_W-1:0] sel;
        logic [BYTE_W-1:0] address;
        logic [BYTE_W-1:0] trans_id;
        logic [BYTE_W-1:0] channel;
        logic [BYTE_W-1:0] command;
        logic [BYTE_W-1:0] len;
        logic [DATA_W-1:0] data;
    } cmd_fields_t;

endpackage

// File: rtl/sca_cmd_receive_if.sv
// UART receive side, SCA transmit lanes and error status of the command receiver.
interface sca_cmd_receive_if;
    import sca_cmd_pkg::*;

    logic [BYTE_W-1:0]        uart_rx_data;
    logic                     uart_rx_valid;
    logic [NUM_CH-1:0]        sca_tx_busy;
    logic [NUM_CH-1:0]        sca_tx_start;
    logic [NUM_CH*BYTE_W-1:0] sca_tx_address;
    logic [NUM_CH*BYTE_W-1:0] sca_tx_transID;
    logic [NUM_CH*BYTE_W-1:0] sca_tx_channel;
    logic [NUM_CH*BYTE_W-1:0] sca_tx_command;
    logic [NUM_CH*BYTE_W-1:0] sca_tx_len;
    logic [NUM_CH*DATA_W-1:0] sca_tx_data;
    logic                     frame_err;
    logic [7:0]               err_count;

    modport master (
        output uart_rx_data, uart_rx_valid, sca_tx_busy,
        input  sca_tx_start, sca_tx_address, sca_tx_transID, sca_tx_channel,
               sca_tx_command, sca_tx_len, sca_tx_data, frame_err, err_count
    );

    modport slave (
        input  uart_rx_data, uart_rx_valid, sca_tx_busy,
        output sca_tx_start, sca_tx_address, sca_tx_transID, sca_tx_channel,
               sca_tx_command, sca_tx_len, sca_tx_data, frame_err, err_count
    );

endinterface

// File: rtl/sca_cmd_frame_collect.sv
// Byte assembly of command frames: sync hunt, field capture, XOR accumulation, inter-byte timeout.
module sca_cmd_frame_collect
    import sca_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              rx_valid_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    output cmd_fields_t       fields_o,
    output logic [BYTE_W-1:0] chk_o,
    output logic [BYTE_W-1:0] acc_o,
    output logic              frame_done_c,
    output logic              frame_timeout_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] acc_q, acc_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_fields_t       fields_q, fields_d;

    // Next-state: store each byte at its index; a received byte always takes priority over timeout.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        acc_d           = acc_q;
        chk_d           = chk_q;
        cnt_d           = cnt_q;
        fields_d        = fields_q;
        frame_done_c    = 1'b0;
        frame_timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d = ST_COLLECT;
                    idx_d   = IDX_SEL;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (rx_valid_i) begin
                    cnt_d = '0;
                    case (idx_q)
                        IDX_SEL:  fields_d.sel          = rx_data_i;
                        IDX_ADDR: fields_d.address      = rx_data_i;
                        IDX_TID:  fields_d.trans_id     = rx_data_i;
                        IDX_CHAN: fields_d.channel      = rx_data_i;
                        IDX_CMD:  fields_d.command      = rx_data_i;
                        IDX_LEN:  fields_d.len          = rx_data_i;
                        IDX_D3:   fields_d.data[31:24]  = rx_data_i;
                        IDX_D2:   fields_d.data[23:16]  = rx_data_i;
                        IDX_D1:   fields_d.data[15:8]   = rx_data_i;
                        IDX_D0:   fields_d.data[7:0]    = rx_data_i;
                        default:  chk_d                 = rx_data_i;
                    endcase
                    if (idx_q == IDX_CHK) begin
                        frame_done_c = 1'b1;
                        state_d      = ST_IDLE;
                        idx_d        = '0;
                    end else begin
                        acc_d = acc_q ^ rx_data_i;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q == CNT_LAST) begin
                    frame_timeout_c = 1'b1;
                    state_d         = ST_IDLE;
                    idx_d           = '0;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Collector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            fields_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            fields_q <= fields_d;
        end
    end

    assign fields_o = fields_q;
    assign chk_o    = chk_q;
    assign acc_o    = acc_q;

endmodule

// File: rtl/sca_cmd_receive.sv
// Validates assembled command frames and dispatches each to one of three SCA transmit lanes.
module sca_cmd_receive
    import sca_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic           clk,
    input logic           rst_n,
    sca_cmd_receive_if.slave bus
);

    state_e                         state_q;
    logic [NUM_CH-1:0]              start_q;
    logic [NUM_CH-1:0][BYTE_W-1:0]  addr_q;
    logic [NUM_CH-1:0][BYTE_W-1:0]  tid_q;
    logic [NUM_CH-1:0][BYTE_W-1:0]  chan_q;
    logic [NUM_CH-1:0][BYTE_W-1:0]  cmd_q;
    logic [NUM_CH-1:0][BYTE_W-1:0]  len_q;
    logic [NUM_CH-1:0][DATA_W-1:0]  data_q;
    logic                           frame_err_q;
    logic [7:0]                     err_count_q;

    cmd_fields_t       fields;
    logic [BYTE_W-1:0] chk;
    logic [BYTE_W-1:0] acc;
    logic              frame_done_c;
    logic              frame_timeout_c;
    logic [1:0]        sel_c;
    logic              chk_bad_c;
    logic              err_event_c;

    // Collector only listens while no frame is being checked or dispatched.
    sca_cmd_frame_collect #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_collect (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (state_q == ST_IDLE),
        .rx_valid_i      (bus.uart_rx_valid),
        .rx_data_i       (bus.uart_rx_data),
        .fields_o        (fields),
        .chk_o           (chk),
        .acc_o           (acc),
        .frame_done_c    (frame_done_c),
        .frame_timeout_c (frame_timeout_c)
    );

    // Frame validity and error event sources.
    always_comb begin
        sel_c       = fields.sel[1:0];
        chk_bad_c   = 1'b0;
        err_event_c = 1'b0;
        if (state_q == ST_CHECK) begin
            chk_bad_c = (chk != acc) || (fields.sel > 8'd2);
        end
        err_event_c = chk_bad_c || frame_timeout_c
                      || (bus.uart_rx_valid && (state_q != ST_IDLE));
    end

    // Dispatch FSM; lane fields and start strobe are loaded on entry to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            addr_q  <= '0;
            tid_q   <= '0;
            chan_q  <= '0;
            cmd_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            start_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_done_c) state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    state_q <= chk_bad_c ? ST_IDLE : ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    if (!bus.sca_tx_busy[sel_c]) begin
                        state_q        <= ST_ISSUE;
                        start_q[sel_c] <= 1'b1;
                        addr_q[sel_c]  <= fields.address;
                        tid_q[sel_c]   <= fields.trans_id;
                        chan_q[sel_c]  <= fields.channel;
                        cmd_q[sel_c]   <= fields.command;
                        len_q[sel_c]   <= fields.len;
                        data_q[sel_c]  <= fields.data;
                    end
                end
                ST_ISSUE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Error pulse and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            frame_err_q <= err_event_c;
            if (err_event_c && (err_count_q != ERR_MAX)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign bus.sca_tx_start   = start_q;
    assign bus.sca_tx_address = addr_q;
    assign bus.sca_tx_transID = tid_q;
    assign bus.sca_tx_channel = chan_q;
    assign bus.sca_tx_command = cmd_q;
    assign bus.sca_tx_len     = len_q;
    assign bus.sca_tx_data    = data_q;
    assign bus.frame_err      = frame_err_q;
    assign bus.err_count      = err_count_q;

endmodule

// File: tb/tb_sca_cmd_receive.sv
// Directed bench for sca_cmd_receive: frame table plus busy, timeout and reset sequences.
module tb_sca_cmd_receive;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    sca_cmd_receive_if bus();

    sca_cmd_receive #(.TIMEOUT_CYCLES(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    int start_cnt [3] = '{0, 0, 0};
    int err_pulses = 0;
    int multi_start = 0;
    int last_start_cyc = 0;
    int chk_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < 3; l++) begin
                if (bus.sca_tx_start[l]) begin
                    start_cnt[l]++;
                    last_start_cyc = cyc;
                end
            end
            if ($countones(bus.sca_tx_start) > 1) multi_start++;
            if (bus.frame_err) err_pulses++;
        end
    end

    // Reference lane contents and error count.
    logic [23:0] m_addr, m_tid, m_chn, m_cmd, m_len;
    logic [95:0] m_data;
    int          m_errc;

    typedef struct {
        logic        pre_en;
        logic [7:0]  pre;
        logic [7:0]  sel, addr, tid, chn, cmd, len;
        logic [31:0] data;
        logic        bad;
        logic [2:0]  exp_start;
        int          exp_err;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0][7:0] build_frame(
        input logic [7:0] sel, addr, tid, chn, cmd, len,
        input logic [31:0] data, input logic bad);
        logic [11:0][7:0] f;
        logic [7:0] x;
        f[0] = 8'h5A; f[1] = sel; f[2] = addr; f[3] = tid; f[4] = chn;
        f[5] = cmd;   f[6] = len;
        f[7] = data[31:24]; f[8] = data[23:16]; f[9] = data[15:8]; f[10] = data[7:0];
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ f[i];
        f[11] = x ^ {7'b0, bad};
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.uart_rx_valid = 1'b0;
        end
    endtask

    // Sends bytes first..last back to back, with gap_len idle cycles after byte gap_idx.
    task automatic send_frame(input logic [11:0][7:0] f, input int first, input int last,
                              input int gap_idx, input int gap_len);
        for (int i = first; i <= last; i++) begin
            send_byte(f[i]);
            if (i == 11) chk_cyc = cyc;
            if (i == gap_idx) idle(gap_len);
        end
        idle(1);
    endtask

    task automatic check_lanes(input string tag);
        check({tag, " address"}, bus.sca_tx_address, m_addr);
        check({tag, " transID"}, bus.sca_tx_transID, m_tid);
        check({tag, " channel"}, bus.sca_tx_channel, m_chn);
        check({tag, " command"}, bus.sca_tx_command, m_cmd);
        check({tag, " len"},     bus.sca_tx_len,     m_len);
        check({tag, " data"},    bus.sca_tx_data,    m_data);
    endtask

    task automatic model_issue(input logic [7:0] sel, addr, tid, chn, cmd, len,
                               input logic [31:0] data);
        int l;
        l = int'(sel);
        m_addr[l*8 +: 8] = addr; m_tid[l*8 +: 8] = tid; m_chn[l*8 +: 8] = chn;
        m_cmd[l*8 +: 8]  = cmd;  m_len[l*8 +: 8] = len; m_data[l*32 +: 32] = data;
    endtask

    task automatic model_err(input int n);
        m_errc = m_errc + n;
        if (m_errc > 255) m_errc = 255;
    endtask

    task automatic model_reset();
        m_addr = '0; m_tid = '0; m_chn = '0; m_cmd = '0; m_len = '0; m_data = '0;
        m_errc = 0;
    endtask

    initial begin
        logic [11:0][7:0] f;
        int s0 [3];
        int e0;
        logic [2:0] got;
        int tot;
        string tag;

        vec[0] = '{1'b0, 8'h00, 8'h01, 8'h10, 8'h22, 8'h03, 8'h04, 8'h04, 32'hDEADBEEF, 1'b0, 3'b010, 0};
        vec[1] = '{1'b0, 8'h00, 8'h01, 8'h10, 8'h22, 8'h03, 8'h04, 8'h04, 32'hDEADBEEF, 1'b1, 3'b000, 1};
        vec[2] = '{1'b0, 8'h00, 8'h03, 8'h55, 8'h66, 8'h77, 8'h88, 8'h01, 32'h12345678, 1'b0, 3'b000, 1};
        vec[3] = '{1'b1, 8'h33, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h02, 32'h01234567, 1'b0, 3'b001, 0};
        vec[4] = '{1'b1, 8'h00, 8'h02, 8'h7E, 8'h01, 8'h0F, 8'h80, 8'h01, 32'hFFFF0000, 1'b0, 3'b100, 0};
        vec[5] = '{1'b0, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 32'h00000000, 1'b0, 3'b000, 1};
        vec[6] = '{1'b0, 8'h00, 8'h01, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hCAFEF00D, 1'b0, 3'b010, 0};

        bus.uart_rx_valid = 1'b0;
        bus.uart_rx_data  = 8'h00;
        bus.sca_tx_busy   = 3'b000;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset start", bus.sca_tx_start, 3'b000);
        check("reset frame_err", bus.frame_err, 1'b0);
        check("reset err_count", bus.err_count, 8'd0);
        check_lanes("reset");
        rst_n = 1'b1;
        idle(2);

        // Frame table.
        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            for (int l = 0; l < 3; l++) s0[l] = start_cnt[l];
            e0 = err_pulses;
            if (vec[i].pre_en) send_byte(vec[i].pre);
            f = build_frame(vec[i].sel, vec[i].addr, vec[i].tid, vec[i].chn, vec[i].cmd,
                            vec[i].len, vec[i].data, vec[i].bad);
            send_frame(f, 0, 11, -1, 0);
            idle(8);
            tot = 0;
            for (int l = 0; l < 3; l++) begin
                got[l] = (start_cnt[l] != s0[l]);
                tot = tot + (start_cnt[l] - s0[l]);
            end
            check({tag, " start lanes"}, got, vec[i].exp_start);
            check({tag, " start pulses"}, tot, $countones(vec[i].exp_start));
            if (vec[i].exp_start != 3'b000) begin
                check({tag, " start latency"}, last_start_cyc - chk_cyc, 3);
                model_issue(vec[i].sel, vec[i].addr, vec[i].tid, vec[i].chn, vec[i].cmd,
                            vec[i].len, vec[i].data);
            end
            model_err(vec[i].exp_err);
            check({tag, " frame_err pulses"}, err_pulses - e0, vec[i].exp_err);
            check({tag, " err_count"}, bus.err_count, m_errc);
            check_lanes(tag);
        end

        // Target busy: start withheld indefinitely, bytes during the wait are rejected.
        bus.sca_tx_busy = 3'b100;
        for (int l = 0; l < 3; l++) s0[l] = start_cnt[l];
        e0 = err_pulses;
        f = build_frame(8'h02, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 32'hA5A5C3C3, 1'b0);
        send_frame(f, 0, 11, -1, 0);
        idle(10);
        check("busy no start early", start_cnt[2] - s0[2], 0);
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h01);
            idle(4);
        end
        model_err(3);
        check("busy discarded bytes", err_pulses - e0, 3);
        check("busy err_count", bus.err_count, m_errc);
        idle(30);
        check("busy no start late", start_cnt[2] - s0[2], 0);
        @(negedge clk);
        bus.sca_tx_busy = 3'b000;
        idle(6);
        model_issue(8'h02, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 32'hA5A5C3C3);
        check("busy release lane2", start_cnt[2] - s0[2], 1);
        check("busy release lane0", start_cnt[0] - s0[0], 0);
        check("busy release lane1", start_cnt[1] - s0[1], 0);
        check_lanes("busy");
        idle(20);
        check("busy single start", start_cnt[2] - s0[2], 1);

        // Inter-byte timeout on a partial frame.
        for (int l = 0; l < 3; l++) s0[l] = start_cnt[l];
        e0 = err_pulses;
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h11);
        idle(25);
        model_err(1);
        check("timeout frame_err", err_pulses - e0, 1);
        check("timeout err_count", bus.err_count, m_errc);
        check("timeout no start", start_cnt[0] - s0[0], 0);

        // A gap one cycle short of the limit is tolerated.
        e0 = err_pulses;
        f = build_frame(8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 32'h25262728, 1'b0);
        send_frame(f, 0, 11, 3, 19);
        idle(8);
        model_issue(8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 32'h25262728);
        check("gap19 start lane0", start_cnt[0] - s0[0], 1);
        check("gap19 no error", err_pulses - e0, 0);
        check_lanes("gap19");

        // A gap equal to the limit aborts the frame; trailing bytes are ignored.
        for (int l = 0; l < 3; l++) s0[l] = start_cnt[l];
        e0 = err_pulses;
        f = build_frame(8'h00, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 32'h35363738, 1'b0);
        send_frame(f, 0, 11, 3, 20);
        idle(8);
        model_err(1);
        check("gap20 frame_err", err_pulses - e0, 1);
        check("gap20 no start", start_cnt[0] - s0[0], 0);
        check_lanes("gap20");

        // Following clean frame issues on lane 0.
        f = build_frame(8'h00, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 32'h25262728, 1'b0);
        send_frame(f, 0, 11, -1, 0);
        idle(8);
        check("post timeout start lane0", start_cnt[0] - s0[0], 1);
        check("post timeout err_count", bus.err_count, m_errc);

        // Reset mid-frame.
        f = build_frame(8'h01, 8'h10, 8'h22, 8'h03, 8'h04, 8'h04, 32'hDEADBEEF, 1'b0);
        send_frame(f, 0, 5, -1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        model_reset();
        check("midreset start", bus.sca_tx_start, 3'b000);
        check("midreset frame_err", bus.frame_err, 1'b0);
        check("midreset err_count", bus.err_count, 8'd0);
        check_lanes("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int l = 0; l < 3; l++) s0[l] = start_cnt[l];
        e0 = err_pulses;
        send_frame(f, 6, 11, -1, 0);
        idle(8);
        tot = (start_cnt[0] - s0[0]) + (start_cnt[1] - s0[1]) + (start_cnt[2] - s0[2]);
        check("midreset tail no start", tot, 0);
        check("midreset tail no error", err_pulses - e0, 0);

        // Saturation of the error counter.
        f = build_frame(8'h01, 8'h10, 8'h22, 8'h03, 8'h04, 8'h04, 32'hDEADBEEF, 1'b1);
        for (int k = 0; k < 260; k++) begin
            send_frame(f, 0, 11, -1, 0);
            idle(3);
        end
        model_err(260);
        check("saturate pulses", err_pulses - e0, 260);
        check("saturate err_count", bus.err_count, m_errc);
        tot = (start_cnt[0] - s0[0]) + (start_cnt[1] - s0[1]) + (start_cnt[2] - s0[2]);
        check("saturate no start", tot, 0);
        check_lanes("saturate");

        check("start one-hot", multi_start, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
